icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter LINES, 32, number of direct-mapped lines (power of two).
REQ-002 Parameter LINE_WORDS, 4, 32-bit words per line (power of two).
REQ-003 Port i_clk  in  1  sole clock; every register updates on its rising edge.
REQ-004 Port i_rst_n  in  1  reset: synchronous, active-low.
REQ-005 Port i_addr  in  32  fetch address (fetch unit's o_if_pc); bits [1:0] ignored.
REQ-006 Port i_flush  in  1  invalidate-all request (fence.i), one-cycle pulse.
REQ-007 Port o_data  out  32  aligned instruction word for i_addr; feeds fetch i_data_in.
REQ-008 Port o_ce  out  1  hit and usable; drives fetch i_clk_ce.
REQ-009 Port o_bus_req  out  1  refill read request.
REQ-010 Port o_bus_addr  out  32  refill word address, bits [1:0]=0.
REQ-011 Port i_bus_ack  in  1  beat accepted; i_bus_data valid this cycle.
REQ-012 Port i_bus_data  in  32  refill beat data.

Function
REQ-013 Address split (defaults): offset = i_addr[3:2], index = i_addr[8:4], tag = i_addr[31:9]; widths derive from LINES and LINE_WORDS.
REQ-014 Tag/data arrays read asynchronously; o_data = data[index][offset] in the same cycle as i_addr; o_data undefined-but-stable on a miss.
REQ-015 Hit = state IDLE && valid[index] && tag[index]==tag && !i_flush; o_ce = hit, combinational.
REQ-016 States: IDLE, REFILL, FLUSH_WAIT; encoding 2 bits.
REQ-017 IDLE, miss (!hit, !i_flush): latch line base {tag,index}, beat counter=0, tag[index] written with new tag, valid[index] cleared; next state REFILL.
REQ-018 REFILL: o_bus_req=1, o_bus_addr = {line base, counter, 2'b00}; o_bus_req held high until ack for each beat, including between beats.
REQ-019 REFILL, i_bus_ack: data[line][counter] <= i_bus_data, counter++; on last beat (counter==LINE_WORDS-1) valid[line] set, o_bus_req dropped next cycle, state IDLE.
REQ-020 Miss penalty with zero-wait ack: miss cycle 0, beats cycles 1..4, o_ce=1 cycle 5.
REQ-021 i_addr changes during REFILL ignored; refill completes on latched line.
REQ-022 i_flush in IDLE: all valid bits cleared at that edge; o_ce=0 that cycle; no refill started that cycle.
REQ-023 i_flush in REFILL: flush pending latched; current beat completes (req not withdrawn before ack); on that ack go FLUSH_WAIT, then all valid cleared, state IDLE; aborted line never marked valid.
REQ-024 i_flush and last-beat ack same cycle: line not validated; all valid cleared.
REQ-025 Offset wrap: counter wraps LINE_WORDS-1 -> 0 only via reset of refill; no overflow into index bits.
REQ-026 Bus data written only on i_bus_ack in REFILL; stray acks in IDLE/FLUSH_WAIT ignored.

Reset
REQ-027 i_rst_n=0 at a rising edge: state IDLE, all valid bits 0, counter 0, flush pending 0, o_bus_req 0, o_bus_addr 0; o_ce 0 while held.
REQ-028 Reset mid-refill aborts immediately: o_bus_req low next cycle; partial line invalid.
REQ-029 Tag and data arrays not reset (contents masked by valid).

Structure
REQ-030 Shared package: LINES/LINE_WORDS defaults, derived OFFSET_W/INDEX_W/TAG_W, state encoding constants.
REQ-031 One sub-module icache_mem_array: tag + data LUT-RAM, async read, single synchronous write port each; valid vector and FSM stay in icache.

Verification
REQ-032 Cold fetch 0x00000000, zero-wait bus returning 0x11,0x22,0x33,0x44 -> req addrs 0x0,0x4,0x8,0xC cycles 1-4; o_ce=1, o_data=0x11 cycle 5.
REQ-033 After fill, i_addr 0x0000000A -> o_ce=1 same cycle, o_data=0x33 (word 2), no o_bus_req.
REQ-034 i_addr 0x00000200 after line 0 filled (same index, tag differs) -> miss, refill from 0x200..0x20C; then 0x00000000 misses again.
REQ-035 Bus ack delayed 3 cycles per beat -> o_bus_req and o_bus_addr stable until each ack; o_ce=0 throughout; fill correct.
REQ-036 i_flush during beat 2 of refill -> beat 2 completes, o_bus_req low after, all lines invalid, next fetch of 0x0 refills.
REQ-037 i_rst_n low during beat 1 -> o_bus_req low next cycle; after release, fetch 0x0 misses and refills.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared icache parameters: default geometry, derived address-field widths, FSM state encoding.
// Widths assume a 32-bit byte address with word-aligned fetches.
package icache_pkg;

  localparam int DEFAULT_LINES      = 32;
  localparam int DEFAULT_LINE_WORDS = 4;

  function automatic int offset_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int line_words);
    return 32 - 2 - $clog2(lines) - $clog2(line_words);
  endfunction

  localparam int OFFSET_W = offset_w(DEFAULT_LINE_WORDS);
  localparam int INDEX_W  = index_w(DEFAULT_LINES);
  localparam int TAG_W    = tag_w(DEFAULT_LINES, DEFAULT_LINE_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_REFILL     = 2'd1,
    ST_FLUSH_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/icache_mem_array.sv
// Tag and data storage for the icache: asynchronous read, one synchronous write port each.
// Zero-cycle read latency; no backpressure, writes land on the rising edge when enabled.
module icache_mem_array
  import icache_pkg::*;
#(
  parameter int LINES      = DEFAULT_LINES,
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
  localparam int IDX_W     = index_w(LINES),
  localparam int OFS_W     = offset_w(LINE_WORDS),
  localparam int TG_W      = tag_w(LINES, LINE_WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [OFS_W-1:0] rd_offset,
  output logic [TG_W-1:0]  rd_tag,
  output logic [31:0]      rd_dat,
  input  logic             tag_we,
  input  logic [IDX_W-1:0] tag_widx,
  input  logic [TG_W-1:0]  tag_wdat,
  input  logic             data_we,
  input  logic [IDX_W-1:0] data_widx,
  input  logic [OFS_W-1:0] data_woff,
  input  logic [31:0]      data_wdat
);

  // Contents are deliberately not reset; the valid vector in the parent masks them.
  logic [TG_W-1:0] tag_mem  [LINES];
  logic [31:0]     data_mem [LINES*LINE_WORDS];

  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem[tag_widx] <= tag_wdat;
    end
    if (data_we) begin
      data_mem[{data_widx, data_woff}] <= data_wdat;
    end
  end

  assign rd_tag = tag_mem[rd_index];
  assign rd_dat = data_mem[{rd_index, rd_offset}];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: same-cycle hit, line refill over a single-beat req/ack bus.
// Miss penalty 1 + LINE_WORDS beats; each beat's request is held until acked.
module icache
  import icache_pkg::*;
#(
  parameter int LINES      = DEFAULT_LINES,
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_addr,
  input  logic        i_flush,
  output logic [31:0] o_data,
  output logic        o_ce,
  output logic        o_bus_req,
  output logic [31:0] o_bus_addr,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_data
);

  localparam int IDX_W = index_w(LINES);
  localparam int OFS_W = offset_w(LINE_WORDS);
  localparam int TG_W  = tag_w(LINES, LINE_WORDS);
  localparam logic [OFS_W-1:0] LAST_BEAT = OFS_W'(LINE_WORDS - 1);

  typedef struct packed {
    logic [TG_W-1:0]  tag;
    logic [IDX_W-1:0] index;
  } line_t;

  state_t           state;
  state_t           state_nxt;
  logic [LINES-1:0] valid;
  line_t            refill_line;
  logic [OFS_W-1:0] beat;
  logic             flush_pend;

  logic [OFS_W-1:0] addr_offset;
  logic [IDX_W-1:0] addr_index;
  logic [TG_W-1:0]  addr_tag;
  logic [TG_W-1:0]  rd_tag;
  logic             lookup_hit;
  logic             tag_we;
  logic             data_we;
  logic             unused_addr_bits;

  assign addr_offset      = i_addr[2 +: OFS_W];
  assign addr_index       = i_addr[2 + OFS_W +: IDX_W];
  assign addr_tag         = i_addr[31 -: TG_W];
  assign unused_addr_bits = ^i_addr[1:0];

  assign lookup_hit = valid[addr_index] && (rd_tag == addr_tag);

  icache_mem_array #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_mem (
    .clk       (i_clk),
    .rd_index  (addr_index),
    .rd_offset (addr_offset),
    .rd_tag    (rd_tag),
    .rd_dat    (o_data),
    .tag_we    (tag_we),
    .tag_widx  (addr_index),
    .tag_wdat  (addr_tag),
    .data_we   (data_we),
    .data_widx (refill_line.index),
    .data_woff (beat),
    .data_wdat (i_bus_data)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A pending or coincident flush aborts the refill on the ack of the beat in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!i_flush && !lookup_hit) begin
          state_nxt = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (i_bus_ack) begin
          if (flush_pend || i_flush) begin
            state_nxt = ST_FLUSH_WAIT;
          end else if (beat == LAST_BEAT) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_FLUSH_WAIT: state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ce       = 1'b0;
    o_bus_req  = 1'b0;
    o_bus_addr = '0;
    tag_we     = 1'b0;
    data_we    = 1'b0;
    case (state)
      ST_IDLE: begin
        o_ce   = i_rst_n && lookup_hit && !i_flush;
        tag_we = !i_flush && !lookup_hit;
      end
      ST_REFILL: begin
        o_bus_req  = 1'b1;
        o_bus_addr = {refill_line, beat, 2'b00};
        data_we    = i_bus_ack;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid       <= '0;
      beat        <= '0;
      flush_pend  <= 1'b0;
      refill_line <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_flush) begin
            valid <= '0;
          end else if (!lookup_hit) begin
            refill_line         <= '{tag: addr_tag, index: addr_index};
            beat                <= '0;
            valid[addr_index]   <= 1'b0;
          end
        end
        ST_REFILL: begin
          if (i_flush) begin
            flush_pend <= 1'b1;
          end
          if (i_bus_ack) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT && !flush_pend && !i_flush) begin
              valid[refill_line.index] <= 1'b1;
            end
          end
        end
        ST_FLUSH_WAIT: begin
          valid      <= '0;
          flush_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: expected refill addresses and fetch words are queued at stimulus
// time and retired when the DUT issues the beat or asserts o_ce.
module tb_icache;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_addr;
  logic        i_flush;
  logic [31:0] o_data;
  logic        o_ce;
  logic        o_bus_req;
  logic [31:0] o_bus_addr;
  logic        i_bus_ack;
  logic [31:0] i_bus_data;

  always #5 clk = ~clk;

  icache dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_addr     (i_addr),
    .i_flush    (i_flush),
    .o_data     (o_data),
    .o_ce       (o_ce),
    .o_bus_req  (o_bus_req),
    .o_bus_addr (o_bus_addr),
    .i_bus_ack  (i_bus_ack),
    .i_bus_data (i_bus_data)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  bit          stray     = 0;
  bit          flush_arm = 0;
  logic [31:0] flush_at  = '0;
  logic [31:0] flush_next = '0;
  logic        s_ce, s_req;
  logic [31:0] s_data, s_addr;

  // Backing memory: the first line holds 0x11..0x44, everything else is address-derived.
  function automatic logic [31:0] bus_word(input logic [31:0] a);
    logic [31:0] k;
    if (a[31:4] == 28'h0) begin
      k = {30'b0, a[3:2]} + 32'd1;
      return k * 32'h11;
    end
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One cycle: sample outputs, act as bus responder, then advance to the next falling edge.
  task automatic step();
    #1;
    s_ce   = o_ce;
    s_data = o_data;
    s_req  = o_bus_req;
    s_addr = o_bus_addr;
    if (s_req === 1'b1) begin
      chk("ce_in_refill", {31'b0, s_ce}, 32'd0);
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_req", {31'b0, s_req}, 32'd0);
      end else begin
        chk("req_addr", s_addr, exp_addr_q[0]);
        if (wait_cnt >= ack_delay) begin
          i_bus_ack  = 1'b1;
          i_bus_data = bus_word(s_addr);
          void'(exp_addr_q.pop_front());
          wait_cnt = 0;
          if (flush_arm && s_addr == flush_at) begin
            i_flush   = 1'b1;
            flush_arm = 0;
            i_addr    = flush_next;
          end
        end else begin
          wait_cnt++;
        end
      end
    end else if (stray) begin
      i_bus_ack  = 1'b1;
      i_bus_data = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    i_bus_ack = 1'b0;
    i_flush   = 1'b0;
  endtask

  task automatic push_line(input logic [31:0] a);
    for (int w = 0; w < 4; w++) begin
      exp_addr_q.push_back({a[31:4], 4'(w * 4)});
    end
  endtask

  task automatic wait_ce(input string tag, input int exp_lat);
    int          lat = 0;
    bit          got = 0;
    logic [31:0] exp_d;
    while (!got && lat < 200) begin
      step();
      if (s_ce === 1'b1) got = 1;
      else lat++;
    end
    exp_d = exp_data_q.pop_front();
    if (got) begin
      chk({tag, "_data"}, s_data, exp_d);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    end else begin
      chk({tag, "_ce"}, {31'b0, s_ce}, 32'd1);
    end
    chk({tag, "_beats"}, 32'(exp_addr_q.size()), 32'd0);
    exp_addr_q.delete();
  endtask

  task automatic fetch(input logic [31:0] a, input bit miss, input int lat, input string tag);
    i_addr = a;
    if (miss) push_line(a);
    exp_data_q.push_back(bus_word({a[31:2], 2'b00}));
    wait_ce(tag, lat);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    i_rst_n    = 1'b0;
    i_addr     = '0;
    i_flush    = 1'b0;
    i_bus_ack  = 1'b0;
    i_bus_data = '0;
    step();
    step();
    chk("rst_req", {31'b0, s_req}, 32'd0);
    chk("rst_addr", s_addr, 32'd0);
    chk("rst_ce", {31'b0, s_ce}, 32'd0);
    i_rst_n = 1'b1;

    fetch(32'h0000_0000, 1, 5, "cold");
    fetch(32'h0000_000A, 0, 0, "hit_w2");
    fetch(32'h0000_000C, 0, 0, "hit_w3");
    fetch(32'h0000_0200, 1, 5, "conflict");
    fetch(32'h0000_0000, 1, 5, "evicted");

    ack_delay = 3;
    fetch(32'h0000_0040, 1, 17, "slow_bus");
    ack_delay = 0;
    fetch(32'h0000_004C, 0, 0, "slow_hit");

    stray = 1;
    fetch(32'h0000_0044, 0, 0, "stray_hit");
    step();
    step();
    step();
    stray = 0;
    fetch(32'h0000_0044, 0, 0, "after_stray");
    fetch(32'h0000_0000, 0, 0, "line0_hit");

    // Flush while idle on a hitting address: no hit, no refill that cycle.
    i_addr  = 32'h0000_0004;
    i_flush = 1'b1;
    step();
    chk("flush_idle_ce", {31'b0, s_ce}, 32'd0);
    chk("flush_idle_req", {31'b0, s_req}, 32'd0);
    fetch(32'h0000_0004, 1, 5, "refetch_4");
    fetch(32'h0000_0040, 1, 5, "flushed_40");

    // Flush on beat 2; fetch moves to 0x0 mid-refill and must refill afterwards.
    i_addr = 32'h0000_0100;
    exp_addr_q.push_back(32'h0000_0100);
    exp_addr_q.push_back(32'h0000_0104);
    push_line(32'h0000_0000);
    exp_data_q.push_back(32'h0000_0011);
    flush_at   = 32'h0000_0104;
    flush_next = 32'h0000_0000;
    flush_arm  = 1;
    wait_ce("flush_mid", 9);
    fetch(32'h0000_0100, 1, 5, "aborted_line");

    // Flush coinciding with the last beat.
    i_addr = 32'h0000_0080;
    push_line(32'h0000_0080);
    push_line(32'h0000_0080);
    exp_data_q.push_back(bus_word(32'h0000_0080));
    flush_at   = 32'h0000_008C;
    flush_next = 32'h0000_0080;
    flush_arm  = 1;
    wait_ce("flush_last", 11);
    fetch(32'h0000_0000, 1, 5, "post_flush_last");

    // Reset asserted while beat 1 is still waiting for its ack.
    ack_delay = 3;
    i_addr    = 32'h0000_0300;
    exp_addr_q.push_back(32'h0000_0300);
    step();
    step();
    i_rst_n = 1'b0;
    step();
    step();
    chk("rst_mid_req", {31'b0, s_req}, 32'd0);
    chk("rst_mid_ce", {31'b0, s_ce}, 32'd0);
    exp_addr_q.delete();
    wait_cnt  = 0;
    ack_delay = 0;
    i_rst_n   = 1'b1;
    fetch(32'h0000_0000, 1, 5, "post_rst_0");
    fetch(32'h0000_0300, 1, 5, "post_rst_300");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
